// File: rtl/sample_serializer.sv
// Sample serializer: buffers decimated sample words in a small FIFO and
// shifts each one out MSB first on a divided bit clock, with a frame sync
// during the MSB and one silent bit period of gap after every frame.
module sample_serializer #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int SCLK_DIV   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              new_data,
  output logic              sclk,
  output logic              sdout,
  output logic              fsync,
  output logic              busy,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int DIVW = $clog2(2 * SCLK_DIV);
  localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2 * SCLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(SCLK_DIV);
  localparam logic [BW-1:0]   BIT_MSB  = BW'(DATA_W - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state_q, state_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;

  logic              nd_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic sclk_d, sdout_d, fsync_d, busy_d, ovf_d;
  logic sclk_q, sdout_q, fsync_q, busy_q, ovf_q;

  logic accept, full, pop, push, drop;

  // Rising-edge strobe detect and FIFO handshake; a pop in the same cycle
  // frees the slot a full-FIFO push needs, so that push is not dropped.
  always_comb begin
    accept = new_data & ~nd_q;
    full   = (cnt_q == CNT_FULL);
    pop    = (state_q == IDLE) && (cnt_q != '0);
    push   = accept && (!full || pop);
    drop   = accept && full && !pop;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ovf_d  = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  // FIFO storage, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // FIFO pointers, occupancy, edge detector and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nd_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      nd_q  <= new_data;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FSM state register with the shift datapath it sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Next-state logic: load on pop, shift per bit period, one gap period.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          sh_d    = mem_q[rd_ptr_q];
          bit_d   = BIT_MSB;
          div_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sh_d  = {sh_q[DATA_W-2:0], 1'b0};
          if (bit_q == '0) state_d = GAP;
          else             bit_d   = bit_q - 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; serial pins lag the FSM by one register stage, while
  // busy is taken from next state so it rises in the accept cycle.
  always_comb begin
    sclk_d  = (state_q == SHIFT) && (div_q >= DIV_HALF);
    sdout_d = (state_q == SHIFT) && sh_q[DATA_W-1];
    fsync_d = (state_q == SHIFT) && (bit_q == BIT_MSB);
    busy_d  = (state_d != IDLE) || (cnt_d != '0);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= 1'b0;
      sdout_q <= 1'b0;
      fsync_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sclk_q  <= sclk_d;
      sdout_q <= sdout_d;
      fsync_q <= fsync_d;
      busy_q  <= busy_d;
    end
  end

  assign sclk     = sclk_q;
  assign sdout    = sdout_q;
  assign fsync    = fsync_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: directed frame timing plus a scoreboard of
// expected words checked by a monitor that samples sdout on sclk rising.
module tb_sample_serializer;

  localparam int DW  = 12;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          new_data = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          sclk, sdout, fsync, busy, overflow;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_rx    = 0;
  logic [DW-1:0] exp_q[$];

  sample_serializer #(.DATA_W(DW), .FIFO_DEPTH(4), .SCLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .new_data(new_data),
    .sclk(sclk), .sdout(sdout), .fsync(fsync), .busy(busy),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitor: a word starts on the sclk rise that carries fsync and ends after DW rises.
  logic          prev_sclk = 1'b0;
  bit            in_word = 1'b0;
  int            nbits = 0;
  logic [DW-1:0] mon_w = '0;
  logic [DW-1:0] mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk = 1'b0;
      in_word   = 1'b0;
      nbits     = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        if (fsync) begin
          check("fsync_only_on_msb", {31'd0, in_word}, 32'd0);
          in_word = 1'b1;
          nbits   = 0;
        end else if (!in_word) begin
          fail_now("stray_sclk_outside_frame");
        end
        if (in_word) begin
          mon_w = {mon_w[DW-2:0], sdout};
          nbits++;
          if (nbits == DW) begin
            in_word = 1'b0;
            n_rx++;
            if (exp_q.size() == 0) fail_now("unexpected_word");
            else begin
              mon_e = exp_q.pop_front();
              check("rx_word", {20'd0, mon_w}, {20'd0, mon_e});
            end
          end
        end
      end
      prev_sclk = sclk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; the rising clock edge inside this task is the accept edge.
  task automatic pulse(input logic [DW-1:0] w);
    data_in  = w;
    new_data = 1'b1;
    tick();
    new_data = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0 && !in_word) break;
      tick();
    end
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  logic [DW-1:0] w;
  int unsigned   rx0;
  int unsigned   idx;

  initial begin
    // Reset state
    #2;
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_sdout", {31'd0, sdout}, 32'd0);
    check("rst_fsync", {31'd0, fsync}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Single word: exact frame timing relative to accept edge E
    w = 12'hA5C;
    exp_q.push_back(w);
    pulse(w);
    for (int k = 1; k <= 106; k++) begin
      tick();
      if (k >= 2 && k <= 97) begin
        idx = (k - 2) / (2 * DIV);
        check("single_sdout", {31'd0, sdout}, {31'd0, w[DW-1-idx]});
        check("single_fsync", {31'd0, fsync}, {31'd0, idx == 0});
        check("single_sclk", {31'd0, sclk}, {31'd0, ((k - 2) % (2 * DIV)) >= DIV});
      end else begin
        check("single_quiet", {29'd0, sclk, sdout, fsync}, 32'd0);
      end
      if (k == 104) check("single_busy_end", {31'd0, busy}, 32'd1);
      if (k == 105) check("single_busy_clear", {31'd0, busy}, 32'd0);
    end
    check("single_queue", exp_q.size(), 32'd0);

    // Burst of 5: first pops at once, remaining 4 fill the FIFO exactly
    for (int i = 1; i <= 5; i++) exp_q.push_back(DW'(i));
    for (int i = 1; i <= 5; i++) begin
      pulse(DW'(i));
      tick();
    end
    check("burst_no_ovf", {31'd0, overflow}, 32'd0);
    drain(1000);
    check("burst_ovf_after", {31'd0, overflow}, 32'd0);

    // Overflow: sixth word finds the FIFO full and is dropped
    for (int i = 1; i <= 5; i++) exp_q.push_back(DW'(i));
    for (int i = 1; i <= 6; i++) begin
      pulse(DW'(i));
      tick();
    end
    check("ovf_set", {31'd0, overflow}, 32'd1);
    drain(1000);
    check("ovf_held", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Decimator cadence with random data
    for (int s = 0; s < 20; s++) begin
      check("cadence_idle_between", {31'd0, busy}, 32'd0);
      w = DW'($urandom);
      exp_q.push_back(w);
      pulse(w);
      repeat (511) tick();
    end
    drain(200);

    // Reset mid-frame with two words queued
    rx0 = n_rx;
    pulse(12'h111); tick();
    pulse(12'h222); tick();
    pulse(12'h333);
    repeat (47) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {27'd0, sclk, sdout, fsync, busy, overflow}, 32'd0);
    repeat (3) tick();
    #3;
    rst_n = 1'b1;
    repeat (300) tick();
    check("midrst_no_frame", n_rx - rx0, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    w = DW'($urandom);
    exp_q.push_back(w);
    pulse(w);
    drain(300);
    check("midrst_new_frame", n_rx - rx0, 32'd1);

    // Held strobe: one accept only, data captured on the first cycle
    rx0 = n_rx;
    w = DW'($urandom);
    exp_q.push_back(w);
    data_in  = w;
    new_data = 1'b1;
    tick();
    data_in = ~w;
    repeat (9) tick();
    new_data = 1'b0;
    drain(400);
    repeat (200) tick();
    check("held_one_word", n_rx - rx0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
